// File: rtl/timer_array.sv
// timer_array
//   NUM_CH independent WIDTH-bit up-counting timers. Each channel is clocked
//   by a shared prescaler, by its own external count clock (tmci), or by the
//   overflow of the channel below it. Each channel has two compare registers.
//   Compare and overflow events set status flags, drive a waveform pin and can
//   start the ADC.
//
// Ports
//   clk       system clock; all state changes on its rising edge
//   rst_n     asynchronous active-low reset
//   tmci      per-channel external count clock (asynchronous)
//   tmri      per-channel external counter reset (asynchronous)
//   wr_en     register write strobe
//   ch        channel select for read and write
//   addr      register select: 0 TCNT, 1 TCORA, 2 TCORB, 3 TCR, 4 TCSR
//   wdata     write data
//   rdata     combinational read of the selected register (0 if reserved)
//   tmo       compare-match waveform outputs
//   cmia      compare-match A interrupts (level)
//   cmib      compare-match B interrupts (level)
//   ovi       overflow interrupts (level)
//   adc_trig  one-clock ADC start pulses
module timer_array #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_CH = 4,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] tmci,
  input  logic [NUM_CH-1:0] tmri,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   ch,
  input  logic [2:0]        addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic [NUM_CH-1:0] tmo,
  output logic [NUM_CH-1:0] cmia,
  output logic [NUM_CH-1:0] cmib,
  output logic [NUM_CH-1:0] ovi,
  output logic [NUM_CH-1:0] adc_trig
);

  localparam logic [2:0] A_TCNT  = 3'd0;
  localparam logic [2:0] A_TCORA = 3'd1;
  localparam logic [2:0] A_TCORB = 3'd2;
  localparam logic [2:0] A_TCR   = 3'd3;
  localparam logic [2:0] A_TCSR  = 3'd4;

  logic [5:0]        presc;
  logic              tick2, tick8, tick64;
  logic [NUM_CH-1:0] tmci_s1, tmci_s2, tmci_s3;
  logic [NUM_CH-1:0] tmri_s1, tmri_s2, tmri_s3;
  logic [NUM_CH-1:0] tmci_rise, tmci_fall, tmri_rise;

  logic [WIDTH-1:0]  tcnt  [NUM_CH];
  logic [WIDTH-1:0]  tcora [NUM_CH];
  logic [WIDTH-1:0]  tcorb [NUM_CH];
  logic [7:0]        tcr   [NUM_CH];
  logic [7:0]        tcsr  [NUM_CH];
  logic [WIDTH-1:0]  tcnt_nxt [NUM_CH];

  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] wr_tcnt, wr_tcora, wr_tcorb, wr_tcr, wr_tcsr;
  logic [NUM_CH-1:0] match_a, match_b, ovf_ev;

  // Output-select action applied to tmo on a compare event.
  function automatic logic os_action(input logic [1:0] os, input logic cur);
    case (os)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~cur;
      default: return cur;
    endcase
  endfunction

  // The prescaler phase is shared by all channels, so ticks line up.
  assign tick2  = presc[0];
  assign tick8  = &presc[2:0];
  assign tick64 = &presc;

  // Edge detect sits behind the two synchroniser flops, so an external edge
  // reaches the counter on the third clock.
  assign tmci_rise = tmci_s2 & ~tmci_s3;
  assign tmci_fall = ~tmci_s2 & tmci_s3;
  assign tmri_rise = tmri_s2 & ~tmri_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      tmci_s1 <= '0;
      tmci_s2 <= '0;
      tmci_s3 <= '0;
      tmri_s1 <= '0;
      tmri_s2 <= '0;
      tmri_s3 <= '0;
    end else begin
      presc   <= presc + 6'd1;
      tmci_s1 <= tmci;
      tmci_s2 <= tmci_s1;
      tmci_s3 <= tmci_s2;
      tmri_s1 <= tmri;
      tmri_s2 <= tmri_s1;
      tmri_s3 <= tmri_s2;
    end
  end

  always_comb begin
    ch_hit   = '0;
    wr_tcnt  = '0;
    wr_tcora = '0;
    wr_tcorb = '0;
    wr_tcr   = '0;
    wr_tcsr  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_hit[i]   = (int'(ch) == i);
      wr_tcnt[i]  = wr_en && ch_hit[i] && (addr == A_TCNT);
      wr_tcora[i] = wr_en && ch_hit[i] && (addr == A_TCORA);
      wr_tcorb[i] = wr_en && ch_hit[i] && (addr == A_TCORB);
      wr_tcr[i]   = wr_en && ch_hit[i] && (addr == A_TCR);
      wr_tcsr[i]  = wr_en && ch_hit[i] && (addr == A_TCSR);
    end
  end

  // Channels are evaluated in ascending order so that a cascaded channel sees
  // the overflow of the channel below it in the same clock. A CPU write to
  // TCNT masks every event; an external clear or a match clear masks overflow.
  always_comb begin
    logic casc;
    logic tk;
    logic tmri_clr;
    logic clr_match;
    casc      = 1'b0;
    tk        = 1'b0;
    tmri_clr  = 1'b0;
    clr_match = 1'b0;
    match_a   = '0;
    match_b   = '0;
    ovf_ev    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (tcr[i][2:0])
        3'd1:    tk = tick2;
        3'd2:    tk = tick8;
        3'd3:    tk = tick64;
        3'd4:    tk = tmci_rise[i];
        3'd5:    tk = tmci_fall[i];
        3'd6:    tk = tmci_rise[i] | tmci_fall[i];
        3'd7:    tk = casc;
        default: tk = 1'b0;
      endcase
      match_a[i] = tk && !wr_tcnt[i] && (tcnt[i] == tcora[i]);
      match_b[i] = tk && !wr_tcnt[i] && (tcnt[i] == tcorb[i]);
      tmri_clr   = (tcr[i][4:3] == 2'b11) && tmri_rise[i];
      clr_match  = ((tcr[i][4:3] == 2'b01) && match_a[i]) ||
                   ((tcr[i][4:3] == 2'b10) && match_b[i]);
      ovf_ev[i]  = tk && !wr_tcnt[i] && !tmri_clr && !clr_match && (&tcnt[i]);
      tcnt_nxt[i] = tcnt[i];
      if (wr_tcnt[i]) begin
        tcnt_nxt[i] = wdata;
      end else if (tmri_clr) begin
        tcnt_nxt[i] = '0;
      end else if (tk) begin
        tcnt_nxt[i] = clr_match ? '0 : tcnt[i] + 1'b1;
      end
      casc = ovf_ev[i];
    end
  end

  // Flags: a set event in the same cycle beats a write-0 clear, and writing 1
  // never sets a flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        tcnt[i]  <= '0;
        tcora[i] <= '1;
        tcorb[i] <= '1;
        tcr[i]   <= '0;
        tcsr[i]  <= '0;
      end
      tmo      <= '0;
      adc_trig <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tcnt[i] <= tcnt_nxt[i];
        if (wr_tcora[i]) tcora[i] <= wdata;
        if (wr_tcorb[i]) tcorb[i] <= wdata;
        if (wr_tcr[i])   tcr[i]   <= wdata[7:0];
        if (wr_tcsr[i])  tcsr[i][4:0] <= wdata[4:0];
        tcsr[i][5] <= ovf_ev[i]  | (tcsr[i][5] & ~(wr_tcsr[i] & ~wdata[5]));
        tcsr[i][6] <= match_a[i] | (tcsr[i][6] & ~(wr_tcsr[i] & ~wdata[6]));
        tcsr[i][7] <= match_b[i] | (tcsr[i][7] & ~(wr_tcsr[i] & ~wdata[7]));
        if (match_b[i]) begin
          tmo[i] <= os_action(tcsr[i][3:2], tmo[i]);
        end else if (match_a[i]) begin
          tmo[i] <= os_action(tcsr[i][1:0], tmo[i]);
        end
        adc_trig[i] <= match_a[i] & tcsr[i][4];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cmia[i] = tcsr[i][6] & tcr[i][5];
      cmib[i] = tcsr[i][7] & tcr[i][6];
      ovi[i]  = tcsr[i][5] & tcr[i][7];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_hit[i]) begin
        case (addr)
          A_TCNT:  rdata = tcnt[i];
          A_TCORA: rdata = tcora[i];
          A_TCORB: rdata = tcorb[i];
          A_TCR:   rdata = WIDTH'(tcr[i]);
          A_TCSR:  rdata = WIDTH'(tcsr[i]);
          default: rdata = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_array.sv
// tb_timer_array
//   Self-checking bench for timer_array (WIDTH 8, NUM_CH 4). A behavioural
//   model tracks every channel from the register rules: prescaler ticks come
//   from the cycle count since reset, and external edges come from a log of
//   sampled pin values. Directed scenarios are followed by randomized traffic.
module tb_timer_array;

  localparam int NCH = 4;
  localparam int LOG = 8192;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] tmci = '0;
  logic [NCH-1:0] tmri = '0;
  logic           wr_en = 1'b0;
  logic [1:0]     ch = '0;
  logic [2:0]     addr = '0;
  logic [7:0]     wdata = '0;
  logic [7:0]     rdata;
  logic [NCH-1:0] tmo, cmia, cmib, ovi, adc_trig;

  int check_count = 0;
  int pass_count  = 0;

  logic [7:0]     m_cnt  [NCH];
  logic [7:0]     m_cora [NCH];
  logic [7:0]     m_corb [NCH];
  logic [7:0]     m_tcr  [NCH];
  logic [7:0]     m_tcsr [NCH];
  logic [NCH-1:0] m_tmo, m_adc;
  int             m_cyc;
  logic [NCH-1:0] tmci_log [LOG];
  logic [NCH-1:0] tmri_log [LOG];

  timer_array #(.WIDTH(8), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .tmci(tmci), .tmri(tmri), .wr_en(wr_en),
    .ch(ch), .addr(addr), .wdata(wdata), .rdata(rdata), .tmo(tmo),
    .cmia(cmia), .cmib(cmib), .ovi(ovi), .adc_trig(adc_trig)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Pin value sampled n clocks after reset; before that the pins look low.
  function automatic logic histBit(input logic is_tmri, input int c, input int n);
    if (n < 0) return 1'b0;
    return is_tmri ? tmri_log[n % LOG][c] : tmci_log[n % LOG][c];
  endfunction

  function automatic logic osApply(input logic [1:0] os, input logic cur);
    case (os)
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      2'd3:    return ~cur;
      default: return cur;
    endcase
  endfunction

  function automatic logic [7:0] modelRead(input int c, input int a);
    case (a)
      0:       return m_cnt[c];
      1:       return m_cora[c];
      2:       return m_corb[c];
      3:       return m_tcr[c];
      4:       return m_tcsr[c];
      default: return 8'h00;
    endcase
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NCH; i++) begin
      m_cnt[i]  = 8'h00;
      m_cora[i] = 8'hFF;
      m_corb[i] = 8'hFF;
      m_tcr[i]  = 8'h00;
      m_tcsr[i] = 8'h00;
    end
    m_tmo = '0;
    m_adc = '0;
    m_cyc = 0;
  endtask

  // One rising clock of the model; every event is derived from the state
  // before the edge, and the cascade carries the lower channel's overflow.
  task automatic modelStep();
    int n;
    int c;
    logic prev_ovf, tk, rise, fall, ma, mb, ovf_e, here, wr_tcsr, tmri_clr;
    logic [1:0] cclr;
    logic [7:0] new_cnt, keep;
    n = m_cyc;
    tmci_log[n % LOG] = tmci;
    tmri_log[n % LOG] = tmri;
    prev_ovf = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      rise = histBit(1'b0, i, n - 2) && !histBit(1'b0, i, n - 3);
      fall = !histBit(1'b0, i, n - 2) && histBit(1'b0, i, n - 3);
      case (m_tcr[i][2:0])
        3'd1:    tk = (n % 2) == 1;
        3'd2:    tk = (n % 8) == 7;
        3'd3:    tk = (n % 64) == 63;
        3'd4:    tk = rise;
        3'd5:    tk = fall;
        3'd6:    tk = rise || fall;
        3'd7:    tk = (i > 0) && prev_ovf;
        default: tk = 1'b0;
      endcase
      cclr     = m_tcr[i][4:3];
      here     = wr_en && (int'(ch) == i);
      tmri_clr = (cclr == 2'd3) && histBit(1'b1, i, n - 2) && !histBit(1'b1, i, n - 3);
      ma = 1'b0; mb = 1'b0; ovf_e = 1'b0;
      new_cnt = m_cnt[i];
      if (here && addr == 3'd0) begin
        new_cnt = wdata;
      end else begin
        ma = tk && (m_cnt[i] == m_cora[i]);
        mb = tk && (m_cnt[i] == m_corb[i]);
        if (tmri_clr) new_cnt = 8'h00;
        else if (tk) begin
          if ((cclr == 2'd1 && ma) || (cclr == 2'd2 && mb)) new_cnt = 8'h00;
          else begin
            c = int'(m_cnt[i]);
            new_cnt = 8'((c + 1) % 256);
            ovf_e = (c + 1) == 256;
          end
        end
      end
      if (mb) m_tmo[i] = osApply(m_tcsr[i][3:2], m_tmo[i]);
      else if (ma) m_tmo[i] = osApply(m_tcsr[i][1:0], m_tmo[i]);
      m_adc[i] = ma && m_tcsr[i][4];
      wr_tcsr = here && addr == 3'd4;
      keep = wr_tcsr ? wdata : 8'hFF;
      m_tcsr[i] = {mb | (m_tcsr[i][7] & keep[7]), ma | (m_tcsr[i][6] & keep[6]),
                   ovf_e | (m_tcsr[i][5] & keep[5]), wr_tcsr ? wdata[4:0] : m_tcsr[i][4:0]};
      if (here && addr == 3'd1) m_cora[i] = wdata;
      if (here && addr == 3'd2) m_corb[i] = wdata;
      if (here && addr == 3'd3) m_tcr[i] = wdata;
      m_cnt[i] = new_cnt;
      prev_ovf = ovf_e;
    end
    m_cyc = m_cyc + 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  // Advance one clock and compare every output plus the selected register.
  task automatic stepCheck();
    logic [NCH-1:0] e_cmia, e_cmib, e_ovi;
    @(posedge clk);
    #2;
    for (int i = 0; i < NCH; i++) begin
      e_cmia[i] = m_tcsr[i][6] & m_tcr[i][5];
      e_cmib[i] = m_tcsr[i][7] & m_tcr[i][6];
      e_ovi[i]  = m_tcsr[i][5] & m_tcr[i][7];
    end
    checkOutput("tmo", tmo, m_tmo);
    checkOutput("cmia", cmia, e_cmia);
    checkOutput("cmib", cmib, e_cmib);
    checkOutput("ovi", ovi, e_ovi);
    checkOutput("adc_trig", adc_trig, m_adc);
    checkOutput("rdata", rdata, modelRead(int'(ch), int'(addr)));
  endtask

  task automatic applyStimulus(input int c, input int a, input logic [7:0] d);
    wr_en = 1'b1;
    ch    = 2'(c);
    addr  = 3'(a);
    wdata = d;
    stepCheck();
    wr_en = 1'b0;
  endtask

  task automatic expectReg(input string tag, input int c, input int a, input logic [7:0] exp);
    ch   = 2'(c);
    addr = 3'(a);
    #1;
    checkOutput(tag, rdata, exp);
  endtask

  task automatic doReset();
    wr_en = 1'b0; ch = '0; addr = '0; wdata = '0; tmci = '0; tmri = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int times[$];
    int maxv;
    int k;
    logic last;

    // Reset values of every register and output.
    doReset();
    for (int c = 0; c < NCH; c++) begin
      stepCheck();
      expectReg("rst tcnt", c, 0, 8'h00);
      expectReg("rst tcora", c, 1, 8'hFF);
      expectReg("rst tcorb", c, 2, 8'hFF);
      expectReg("rst tcr", c, 3, 8'h00);
      expectReg("rst tcsr", c, 4, 8'h00);
      expectReg("rst reserved", c, 5, 8'h00);
    end
    checkOutput("rst outputs", {tmo, cmia, cmib, ovi, adc_trig}, 0);

    // clk/2 with clear on match A at 4, toggle output: period 10 clocks.
    applyStimulus(0, 1, 8'h04);
    applyStimulus(0, 4, 8'h03);
    applyStimulus(0, 3, 8'h09);
    ch = 2'd0; addr = 3'd0;
    last = tmo[0]; maxv = 0;
    for (int j = 0; j < 80; j++) begin
      stepCheck();
      if (int'(rdata) > maxv) maxv = int'(rdata);
      if (tmo[0] !== last) begin
        times.push_back(j);
        last = tmo[0];
      end
    end
    checkOutput("t1 tcnt max", maxv, 4);
    checkOutput("t1 toggle count>=4", times.size() >= 4, 1);
    for (int j = 1; j < times.size(); j++) checkOutput("t1 toggle period", times[j] - times[j-1], 10);
    expectReg("t1 cmfa set", 0, 4, 8'h43);

    // Overflow from 0xFE after two clk/2 ticks, then flag clear.
    applyStimulus(1, 0, 8'hFE);
    applyStimulus(1, 3, 8'h81);
    ch = 2'd1; addr = 3'd0;
    k = 0;
    do begin
      stepCheck();
      k++;
    end while (rdata != 8'h00 && k < 20);
    checkOutput("t2 wrap to 0", rdata, 8'h00);
    checkOutput("t2 ovi set", ovi[1], 1'b1);
    expectReg("t2 tcsr flags", 1, 4, 8'hE0);
    applyStimulus(1, 4, 8'h00);
    checkOutput("t2 ovi cleared", ovi[1], 1'b0);

    // Cascade: channel 1 counts in the same clock as channel 0 wraps.
    doReset();
    applyStimulus(1, 3, 8'h07);
    applyStimulus(0, 0, 8'hFF);
    applyStimulus(0, 3, 8'h81);
    ch = 2'd1; addr = 3'd0;
    k = 0;
    stepCheck();
    while (!ovi[0] && k < 20) begin
      checkOutput("t3 ch1 before wrap", rdata, 8'h00);
      stepCheck();
      k++;
    end
    checkOutput("t3 ovi0", ovi[0], 1'b1);
    checkOutput("t3 ch1 same clk", rdata, 8'h01);

    // Falling-edge external clock: 3 clocks latency, rising edges ignored.
    applyStimulus(2, 3, 8'h05);
    ch = 2'd2; addr = 3'd0;
    for (int p = 0; p < 3; p++) begin
      tmci[2] = 1'b1;
      repeat (4) stepCheck();
      checkOutput("t4 rise ignored", rdata, p);
      tmci[2] = 1'b0;
      repeat (2) stepCheck();
      checkOutput("t4 not before 3 clks", rdata, p);
      stepCheck();
      checkOutput("t4 count at 3 clks", rdata, p + 1);
    end

    // External reset pin clears after 3 clocks.
    applyStimulus(3, 3, 8'h18);
    applyStimulus(3, 0, 8'h20);
    ch = 2'd3; addr = 3'd0;
    tmri[3] = 1'b1;
    stepCheck();
    tmri[3] = 1'b0;
    stepCheck();
    checkOutput("t5 tmri before", rdata, 8'h20);
    stepCheck();
    checkOutput("t5 tmri cleared", rdata, 8'h00);

    // Flag clear write coincident with a match: the set wins.
    applyStimulus(3, 3, 8'h00);
    applyStimulus(3, 1, 8'h05);
    applyStimulus(3, 0, 8'h04);
    applyStimulus(3, 3, 8'h21);
    k = 0;
    while (!cmia[3] && k < 20) begin
      stepCheck();
      k++;
    end
    checkOutput("t5 first match", cmia[3], 1'b1);
    if (m_cyc % 2 != 0) stepCheck();
    applyStimulus(3, 0, 8'h05);
    applyStimulus(3, 4, 8'h00);
    checkOutput("t5 set beats clear", cmia[3], 1'b1);
    expectReg("t5 tcsr", 3, 4, 8'h40);
    applyStimulus(3, 4, 8'h00);
    checkOutput("t5 clear later", cmia[3], 1'b0);

    // Asynchronous reset while counting with tmo high.
    doReset();
    applyStimulus(0, 1, 8'h04);
    applyStimulus(0, 4, 8'h03);
    applyStimulus(0, 3, 8'h29);
    k = 0;
    while (!tmo[0] && k < 40) begin
      stepCheck();
      k++;
    end
    checkOutput("t6 tmo high", tmo[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6 async outputs", {tmo, cmia, cmib, ovi, adc_trig}, 0);
    expectReg("t6 async tcnt", 0, 0, 8'h00);
    expectReg("t6 async tcora", 0, 1, 8'hFF);
    expectReg("t6 async tcr", 0, 3, 8'h00);
    stepCheck();
    rst_n = 1'b1;
    repeat (10) stepCheck();
    expectReg("t6 stays stopped", 0, 0, 8'h00);

    // Randomized traffic against the model.
    doReset();
    for (int j = 0; j < 3000; j++) begin
      wr_en = ($urandom_range(0, 5) == 0);
      ch    = 2'($urandom_range(0, 3));
      addr  = 3'($urandom_range(0, 7));
      wdata = 8'($urandom);
      if (addr == 3'd0 && $urandom_range(0, 1) == 1) wdata = 8'hF0 | 8'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) == 0) tmci[i] = ~tmci[i];
        if ($urandom_range(0, 11) == 0) tmri[i] = ~tmri[i];
      end
      stepCheck();
    end
    wr_en = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
